// File: rtl/parking_pkg.sv
// Shared types and constants for the parking front-end.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: gate state encoding, default timing constants, class encoding,
// and the vacancy lookup used when an entry is issued.
package parking_pkg;

  typedef enum logic [1:0] {
    GATE_IDLE       = 2'd0,
    GATE_OPEN       = 2'd1,
    GATE_WAIT_CLEAR = 2'd2
  } gate_state_t;

  localparam int DEFAULT_DEBOUNCE_CYCLES  = 4;
  localparam int DEFAULT_GATE_OPEN_CYCLES = 8;

  localparam logic CLASS_UNI = 1'b1;

  // Picks the vacancy flag that matches the car's class.
  function automatic logic class_has_space(input logic cls,
                                           input logic uni_vac,
                                           input logic reg_vac);
    return (cls == CLASS_UNI) ? uni_vac : reg_vac;
  endfunction

endpackage

// File: rtl/sensor_debounce.sv
// Synchronises and debounces one raw loop-detector input and flags its rising edge.
// Latency: 2 sync cycles + DEBOUNCE_CYCLES to o_level; o_rise is high in the first cycle o_level is 1.
// Backpressure: none; free-running, the output simply follows the settled sensor.
//
// Ports: clk, rst (sync, active-high), i_raw (asynchronous sensor),
//        o_level (debounced value), o_rise (1-cycle debounced rising edge).
module sensor_debounce
  import parking_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int CNT_W           = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_raw,
  output logic o_level,
  output logic o_rise
);

  localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LP_ONE  = CNT_W'(1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_level;
  logic             r_level_d;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_level   <= 1'b0;
      r_level_d <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_sync1   <= i_raw;
      r_sync2   <= r_sync1;
      r_level_d <= r_level;
      if (r_sync2 == r_level) begin
        // Any agreeing sample restarts the disagreement run.
        r_cnt <= '0;
      end else if (r_cnt == LP_LAST) begin
        // This cycle is the DEBOUNCE_CYCLES-th consecutive disagreement.
        r_level <= ~r_level;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + LP_ONE;
      end
    end
  end

  assign o_level = r_level;
  assign o_rise  = r_level & ~r_level_d;

endmodule

// File: rtl/parking_gate_ctrl.sv
// Parking front-end: debounced entry/exit events, vacancy check, barrier timing.
// Latency: event pulse 1 cycle after the debounced rise (raw rise + 2 + DEBOUNCE_CYCLES + 1); a deferred entry adds 1.
// Backpressure: none; an entry colliding with an exit is held one cycle, rises on a busy gate are dropped.
//
// Ports: clk, rst (sync, active-high); entry_sensor/entry_is_uni, exit_sensor/exit_is_uni (raw inputs);
//        uni_is_vacated_space/is_vacated_space (core vacancy flags);
//        car_entered/is_uni_car_entered, car_exited/is_uni_car_exited, entry_rejected (1-cycle pulses);
//        entry_gate_open/exit_gate_open (barrier drives).
module parking_gate_ctrl
  import parking_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES  = DEFAULT_DEBOUNCE_CYCLES,
  parameter int GATE_OPEN_CYCLES = DEFAULT_GATE_OPEN_CYCLES,
  parameter int CNT_W            = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic entry_sensor,
  input  logic entry_is_uni,
  input  logic exit_sensor,
  input  logic exit_is_uni,
  input  logic uni_is_vacated_space,
  input  logic is_vacated_space,
  output logic car_entered,
  output logic is_uni_car_entered,
  output logic car_exited,
  output logic is_uni_car_exited,
  output logic entry_gate_open,
  output logic exit_gate_open,
  output logic entry_rejected
);

  localparam logic [CNT_W-1:0] LP_GATE_LOAD = CNT_W'(GATE_OPEN_CYCLES);
  localparam logic [CNT_W-1:0] LP_ONE       = CNT_W'(1);

  logic w_en_level, w_en_rise;
  logic w_ex_level, w_ex_rise;

  sensor_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_entry_db (
    .clk     (clk),
    .rst     (rst),
    .i_raw   (entry_sensor),
    .o_level (w_en_level),
    .o_rise  (w_en_rise)
  );

  sensor_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_exit_db (
    .clk     (clk),
    .rst     (rst),
    .i_raw   (exit_sensor),
    .o_level (w_ex_level),
    .o_rise  (w_ex_rise)
  );

  gate_state_t      r_en_state, w_en_state_nxt;
  gate_state_t      r_ex_state, w_ex_state_nxt;
  logic [CNT_W-1:0] r_en_cnt, w_en_cnt_nxt;
  logic [CNT_W-1:0] r_ex_cnt, w_ex_cnt_nxt;

  logic r_pend, r_pend_cls;
  logic r_car_entered, r_is_uni_entered;
  logic r_car_exited, r_is_uni_exited;
  logic r_entry_rejected;

  // Arbitration: exit wins a collision, the entry waits one cycle in r_pend.
  logic w_ex_issue;
  logic w_en_new, w_en_cand, w_en_cls;
  logic w_en_defer, w_en_go, w_en_accept, w_en_reject;

  assign w_ex_issue  = w_ex_rise & (r_ex_state == GATE_IDLE);
  assign w_en_new    = w_en_rise & (r_en_state == GATE_IDLE) & ~r_pend;
  assign w_en_cand   = r_pend | w_en_new;
  assign w_en_cls    = r_pend ? r_pend_cls : entry_is_uni;
  assign w_en_defer  = w_en_cand & w_ex_issue;
  assign w_en_go     = w_en_cand & ~w_ex_issue;
  // Vacancy is judged with the flags present in the issue cycle, so a
  // deferred entry sees the core's state one cycle later.
  assign w_en_accept = w_en_go & class_has_space(w_en_cls, uni_is_vacated_space, is_vacated_space);
  assign w_en_reject = w_en_go & ~class_has_space(w_en_cls, uni_is_vacated_space, is_vacated_space);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_en_state       <= GATE_IDLE;
      r_ex_state       <= GATE_IDLE;
      r_en_cnt         <= '0;
      r_ex_cnt         <= '0;
      r_pend           <= 1'b0;
      r_pend_cls       <= 1'b0;
      r_car_entered    <= 1'b0;
      r_is_uni_entered <= 1'b0;
      r_car_exited     <= 1'b0;
      r_is_uni_exited  <= 1'b0;
      r_entry_rejected <= 1'b0;
    end else begin
      r_en_state       <= w_en_state_nxt;
      r_ex_state       <= w_ex_state_nxt;
      r_en_cnt         <= w_en_cnt_nxt;
      r_ex_cnt         <= w_ex_cnt_nxt;
      r_pend           <= w_en_defer;
      r_pend_cls       <= w_en_defer & w_en_cls;
      r_car_entered    <= w_en_accept;
      r_is_uni_entered <= w_en_accept & w_en_cls;
      r_car_exited     <= w_ex_issue;
      r_is_uni_exited  <= w_ex_issue & exit_is_uni;
      r_entry_rejected <= w_en_reject;
    end
  end

  // Entry barrier: stays open for the minimum time, then until the car clears the loop.
  always_comb begin
    w_en_state_nxt = r_en_state;
    w_en_cnt_nxt   = r_en_cnt;
    case (r_en_state)
      GATE_IDLE: begin
        if (w_en_accept) begin
          w_en_state_nxt = GATE_OPEN;
          w_en_cnt_nxt   = LP_GATE_LOAD;
        end
      end
      GATE_OPEN: begin
        if (r_en_cnt <= LP_ONE) begin
          w_en_state_nxt = GATE_WAIT_CLEAR;
          w_en_cnt_nxt   = '0;
        end else begin
          w_en_cnt_nxt = r_en_cnt - LP_ONE;
        end
      end
      GATE_WAIT_CLEAR: begin
        if (!w_en_level) begin
          w_en_state_nxt = GATE_IDLE;
        end
      end
      default: begin
        w_en_state_nxt = GATE_IDLE;
        w_en_cnt_nxt   = '0;
      end
    endcase
  end

  // Exit barrier: same timing, every exit is admitted.
  always_comb begin
    w_ex_state_nxt = r_ex_state;
    w_ex_cnt_nxt   = r_ex_cnt;
    case (r_ex_state)
      GATE_IDLE: begin
        if (w_ex_issue) begin
          w_ex_state_nxt = GATE_OPEN;
          w_ex_cnt_nxt   = LP_GATE_LOAD;
        end
      end
      GATE_OPEN: begin
        if (r_ex_cnt <= LP_ONE) begin
          w_ex_state_nxt = GATE_WAIT_CLEAR;
          w_ex_cnt_nxt   = '0;
        end else begin
          w_ex_cnt_nxt = r_ex_cnt - LP_ONE;
        end
      end
      GATE_WAIT_CLEAR: begin
        if (!w_ex_level) begin
          w_ex_state_nxt = GATE_IDLE;
        end
      end
      default: begin
        w_ex_state_nxt = GATE_IDLE;
        w_ex_cnt_nxt   = '0;
      end
    endcase
  end

  assign car_entered        = r_car_entered;
  assign is_uni_car_entered = r_is_uni_entered;
  assign car_exited         = r_car_exited;
  assign is_uni_car_exited  = r_is_uni_exited;
  assign entry_rejected     = r_entry_rejected;
  assign entry_gate_open    = (r_en_state != GATE_IDLE);
  assign exit_gate_open     = (r_ex_state != GATE_IDLE);

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Self-checking bench for parking_gate_ctrl: timeline model plus directed literal checks.
// Latency: n/a.
// Backpressure: n/a.
module tb_parking_gate_ctrl;

  localparam int DB   = 4;
  localparam int GO   = 8;
  localparam int MAXC = 8192;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic entry_sensor = 1'b0;
  logic entry_is_uni = 1'b0;
  logic exit_sensor = 1'b0;
  logic exit_is_uni = 1'b0;
  logic uni_is_vacated_space = 1'b0;
  logic is_vacated_space = 1'b0;
  logic car_entered, is_uni_car_entered, car_exited, is_uni_car_exited;
  logic entry_gate_open, exit_gate_open, entry_rejected;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  parking_gate_ctrl #(
    .DEBOUNCE_CYCLES  (DB),
    .GATE_OPEN_CYCLES (GO),
    .CNT_W            (4)
  ) dut (
    .clk                  (clk),
    .rst                  (rst),
    .entry_sensor         (entry_sensor),
    .entry_is_uni         (entry_is_uni),
    .exit_sensor          (exit_sensor),
    .exit_is_uni          (exit_is_uni),
    .uni_is_vacated_space (uni_is_vacated_space),
    .is_vacated_space     (is_vacated_space),
    .car_entered          (car_entered),
    .is_uni_car_entered   (is_uni_car_entered),
    .car_exited           (car_exited),
    .is_uni_car_exited    (is_uni_car_exited),
    .entry_gate_open      (entry_gate_open),
    .exit_gate_open       (exit_gate_open),
    .entry_rejected       (entry_rejected)
  );

  task automatic chk(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %b, expected %b", nm, cyc, act, exp);
    end
  endtask

  // ---------------- timeline model ----------------
  // Per-edge history of what was sampled; the debounced level is derived from
  // a sliding window of synchronised samples.
  bit rst_h [0:MAXC-1];
  bit raw_en[0:MAXC-1];
  bit raw_ex[0:MAXC-1];
  bit deb_en[0:MAXC-1];
  bit deb_ex[0:MAXC-1];

  bit m_started = 0;
  bit m_ce = 0, m_cec = 0, m_cx = 0, m_cxc = 0, m_rej = 0;
  bit en_busy = 0, ex_busy = 0, pend = 0, pend_cls = 0;
  int en_open_e = 0, ex_open_e = 0;

  // Sample the debouncer sees at edge e: raw from two edges earlier, zero if
  // either synchroniser stage was being reset in between.
  function automatic bit sync_at(input int e, input bit ex);
    if (e < 3) return 1'b0;
    if (rst_h[e-1] || rst_h[e-2]) return 1'b0;
    return ex ? raw_ex[e-2] : raw_en[e-2];
  endfunction

  // The level flips once the last DB samples (none across a reset) all disagree with it.
  function automatic bit next_deb(input int e, input bit ex);
    bit prev;
    prev = ex ? deb_ex[e-1] : deb_en[e-1];
    if (e <= DB) return prev;
    for (int j = 0; j < DB; j++) begin
      if (j > 0 && rst_h[e-j]) return prev;
      if (sync_at(e-j, ex) == prev) return prev;
    end
    return !prev;
  endfunction

  always @(posedge clk) begin : model
    int  e;
    bit  ev_en, ev_ex, pre_en, pre_ex, cand, ccls, room;
    cyc = cyc + 1;
    e = cyc;
    if (e >= MAXC) begin
      $display("FAIL model_history_overflow at cycle %0d: got %0d, expected < %0d", cyc, e, MAXC);
      $fatal(1);
    end
    rst_h[e]  = rst;
    raw_en[e] = entry_sensor;
    raw_ex[e] = exit_sensor;
    m_ce = 0; m_cec = 0; m_cx = 0; m_cxc = 0; m_rej = 0;
    if (rst) begin
      en_busy = 0; ex_busy = 0; pend = 0; pend_cls = 0;
      deb_en[e] = 0; deb_ex[e] = 0;
    end else begin
      ev_en  = (e >= 2) && deb_en[e-1] && !deb_en[e-2];
      ev_ex  = (e >= 2) && deb_ex[e-1] && !deb_ex[e-2];
      pre_en = en_busy;
      pre_ex = ex_busy;
      // Earliest close is GO+1 edges after opening, once the car has left the loop.
      if (en_busy && e >= en_open_e + GO + 1 && !deb_en[e-1]) en_busy = 0;
      if (ex_busy && e >= ex_open_e + GO + 1 && !deb_ex[e-1]) ex_busy = 0;
      if (ev_ex && !pre_ex) begin
        m_cx = 1; m_cxc = exit_is_uni; ex_busy = 1; ex_open_e = e;
      end
      cand = 0; ccls = 0;
      if (pend) begin
        cand = 1; ccls = pend_cls;
      end else if (ev_en && !pre_en) begin
        cand = 1; ccls = entry_is_uni;
      end
      if (cand) begin
        if (m_cx) begin
          pend = 1; pend_cls = ccls;
        end else begin
          pend = 0; pend_cls = 0;
          room = ccls ? uni_is_vacated_space : is_vacated_space;
          if (room) begin
            m_ce = 1; m_cec = ccls; en_busy = 1; en_open_e = e;
          end else begin
            m_rej = 1;
          end
        end
      end
      deb_en[e] = next_deb(e, 1'b0);
      deb_ex[e] = next_deb(e, 1'b1);
    end
    m_started = 1;
  end

  always @(negedge clk) begin
    if (m_started) begin
      chk("model_car_entered",   car_entered,        m_ce);
      chk("model_uni_entered",   is_uni_car_entered, m_cec);
      chk("model_car_exited",    car_exited,         m_cx);
      chk("model_uni_exited",    is_uni_car_exited,  m_cxc);
      chk("model_rejected",      entry_rejected,     m_rej);
      chk("model_entry_gate",    entry_gate_open,    en_busy);
      chk("model_exit_gate",     exit_gate_open,     ex_busy);
      chk("model_not_both",      car_entered & car_exited, 1'b0);
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_closed();
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (!entry_gate_open && !exit_gate_open) break;
    end
    chk("gates_close_in_time", entry_gate_open | exit_gate_open, 1'b0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int len_en, len_ex;

    // Reset with both sensors high: everything quiet, then both re-debounce.
    entry_sensor = 1; exit_sensor = 1;
    is_vacated_space = 1; uni_is_vacated_space = 1;
    entry_is_uni = 0; exit_is_uni = 0;
    rst = 1;
    repeat (3) begin
      @(negedge clk);
      chk("reset_outputs_zero", |{car_entered, is_uni_car_entered, car_exited, is_uni_car_exited,
                                  entry_gate_open, exit_gate_open, entry_rejected}, 1'b0);
    end
    rst = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      chk("post_reset_exit_pulse",  car_exited,  (k == 7));
      chk("post_reset_entry_pulse", car_entered, (k == 8));
    end
    entry_sensor = 0; exit_sensor = 0;
    wait_closed();

    // Regular entry, sensor held 12 cycles.
    entry_is_uni = 0; is_vacated_space = 1; uni_is_vacated_space = 0;
    entry_sensor = 1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      chk("reg_entry_pulse", car_entered,        (k == 7));
      chk("reg_entry_class", is_uni_car_entered, 1'b0);
      chk("reg_entry_norej", entry_rejected,     1'b0);
      chk("reg_entry_gate",  entry_gate_open,    (k >= 7 && k <= 18));
      if (k == 12) entry_sensor = 0;
    end
    wait_closed();

    // Uni entry with uni spaces full.
    entry_is_uni = 1; uni_is_vacated_space = 0; is_vacated_space = 1;
    entry_sensor = 1;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      chk("uni_full_reject",   entry_rejected,  (k == 7));
      chk("uni_full_no_entry", car_entered,     1'b0);
      chk("uni_full_gate",     entry_gate_open, 1'b0);
      if (k == 8) entry_sensor = 0;
    end
    repeat (4) @(negedge clk);

    // Three-cycle glitch.
    uni_is_vacated_space = 1;
    entry_sensor = 1;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      chk("glitch_no_entry", car_entered,     1'b0);
      chk("glitch_no_rej",   entry_rejected,  1'b0);
      chk("glitch_gate",     entry_gate_open, 1'b0);
      if (k == 3) entry_sensor = 0;
    end

    // Simultaneous arrivals: exit first, entry one cycle later.
    exit_is_uni = 1; entry_is_uni = 0; is_vacated_space = 1;
    entry_sensor = 1; exit_sensor = 1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      chk("simul_exit_pulse",  car_exited,         (k == 7));
      chk("simul_exit_class",  is_uni_car_exited,  (k == 7));
      chk("simul_entry_pulse", car_entered,        (k == 8));
      chk("simul_entry_class", is_uni_car_entered, 1'b0);
    end
    entry_sensor = 0; exit_sensor = 0;
    wait_closed();

    // Reset while the entry gate is open.
    entry_is_uni = 0; is_vacated_space = 1;
    entry_sensor = 1;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      if (k == 7) chk("midrst_entry_pulse", car_entered, 1'b1);
    end
    chk("midrst_gate_before", entry_gate_open, 1'b1);
    rst = 1;
    @(negedge clk);
    chk("midrst_gate_closed", entry_gate_open, 1'b0);
    chk("midrst_all_zero", |{car_entered, car_exited, entry_rejected, exit_gate_open}, 1'b0);
    entry_sensor = 0;
    rst = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      chk("midrst_no_stale", car_entered | entry_rejected | entry_gate_open, 1'b0);
    end

    // Randomised traffic against the model.
    len_en = 0; len_ex = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (len_en == 0) begin
        entry_sensor = ~entry_sensor;
        len_en = int'($urandom_range(1, 24));
        if (entry_sensor && !exit_sensor && $urandom_range(0, 2) == 0) begin
          exit_sensor = 1;
          len_ex = len_en;
        end
      end else begin
        len_en--;
      end
      if (len_ex == 0) begin
        exit_sensor = ~exit_sensor;
        len_ex = int'($urandom_range(1, 24));
      end else begin
        len_ex--;
      end
      if ($urandom_range(0, 3) == 0) entry_is_uni = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) exit_is_uni = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) uni_is_vacated_space = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) is_vacated_space = 1'($urandom_range(0, 1));
      rst = ($urandom_range(0, 599) == 0);
    end
    rst = 0; entry_sensor = 0; exit_sensor = 0;
    repeat (30) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
